// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands/control, detects load-use
// hazards, inserts bubbles, and muxes forwarded operands for the ALU.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid_in,
    input  logic [4:0]        id_rs1_in,
    input  logic [4:0]        id_rs2_in,
    input  logic [4:0]        id_rd_in,
    input  logic              id_reg_wr_in,
    input  logic              id_mem_rd_in,
    input  logic [XLEN-1:0]   id_rs1_data_in,
    input  logic [XLEN-1:0]   id_rs2_data_in,
    input  logic [XLEN-1:0]   id_imm_in,
    input  logic [CTRL_W-1:0] id_ctrl_in,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic [1:0]        fwd_rs1_in,
    input  logic [1:0]        fwd_rs2_in,
    input  logic [XLEN-1:0]   fwd_ex_data_in,
    input  logic [XLEN-1:0]   fwd_mem_data_in,
    output logic              ex_valid_out,
    output logic [4:0]        ex_rs1_out,
    output logic [4:0]        ex_rs2_out,
    output logic [4:0]        ex_rd_out,
    output logic              ex_reg_wr_out,
    output logic              ex_mem_rd_out,
    output logic [XLEN-1:0]   ex_imm_out,
    output logic [CTRL_W-1:0] ex_ctrl_out,
    output logic [XLEN-1:0]   ex_op_a_out,
    output logic [XLEN-1:0]   ex_op_b_out,
    output logic              stall_out,
    output logic [CNT_W-1:0]  bubble_cnt_out
);

    logic              valid_p1, reg_wr_p1, mem_rd_p1;
    logic [4:0]        rs1_p1, rs2_p1, rd_p1;
    logic [XLEN-1:0]   rs1_data_p1, rs2_data_p1, imm_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [CNT_W-1:0]  bubble_cnt_p1;
    logic              hazard;
    logic              kill;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Code 11 picks EX/MEM: it is the younger of the two producers.
    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] ex_d,
                                                input logic [XLEN-1:0] mem_d,
                                                input logic [XLEN-1:0] reg_d);
        return sel[1] ? ex_d : (sel[0] ? mem_d : reg_d);
    endfunction

    assign hazard = id_valid_in & valid_p1 & mem_rd_p1 & (rd_p1 != 5'd0) &
                    ((id_rs1_in == rd_p1) | (id_rs2_in == rd_p1));
    assign kill   = flush_in | hazard;

    // ---- ID -> EX register (p1) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_p1      <= 1'b0;
            reg_wr_p1     <= 1'b0;
            mem_rd_p1     <= 1'b0;
            rs1_p1        <= '0;
            rs2_p1        <= '0;
            rd_p1         <= '0;
            rs1_data_p1   <= '0;
            rs2_data_p1   <= '0;
            imm_p1        <= '0;
            ctrl_p1       <= '0;
            bubble_cnt_p1 <= '0;
        end else if (flush_in || !stall_in) begin
            valid_p1    <= id_valid_in & ~kill;
            reg_wr_p1   <= id_valid_in & id_reg_wr_in & ~kill;
            mem_rd_p1   <= id_valid_in & id_mem_rd_in & ~kill;
            rs1_p1      <= kill ? 5'd0 : id_rs1_in;
            rs2_p1      <= kill ? 5'd0 : id_rs2_in;
            rd_p1       <= kill ? 5'd0 : id_rd_in;
            rs1_data_p1 <= kill ? '0 : id_rs1_data_in;
            rs2_data_p1 <= kill ? '0 : id_rs2_data_in;
            imm_p1      <= kill ? '0 : id_imm_in;
            ctrl_p1     <= kill ? '0 : id_ctrl_in;
            // Flush bubbles are redirects, not hazard stalls, so they are not counted.
            if (hazard && !flush_in)
                bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
        end
    end

    assign ex_valid_out   = valid_p1;
    assign ex_rs1_out     = rs1_p1;
    assign ex_rs2_out     = rs2_p1;
    assign ex_rd_out      = rd_p1;
    assign ex_reg_wr_out  = reg_wr_p1;
    assign ex_mem_rd_out  = mem_rd_p1;
    assign ex_imm_out     = imm_p1;
    assign ex_ctrl_out    = ctrl_p1;
    assign bubble_cnt_out = bubble_cnt_p1;
    assign stall_out      = hazard & ~flush_in;
    assign ex_op_a_out    = fwd_mux(fwd_rs1_in, fwd_ex_data_in, fwd_mem_data_in, rs1_data_p1);
    assign ex_op_b_out    = fwd_mux(fwd_rs2_in, fwd_ex_data_in, fwd_mem_data_in, rs2_data_p1);

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: driver pushes model predictions, monitor
// pops and compares each cycle on the falling edge.
`timescale 1ns/1ps
module tb_id_ex_stage;
    localparam int XLEN   = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, id_valid_in, id_reg_wr_in, id_mem_rd_in, stall_in, flush_in;
    logic [4:0]        id_rs1_in, id_rs2_in, id_rd_in;
    logic [XLEN-1:0]   id_rs1_data_in, id_rs2_data_in, id_imm_in, fwd_ex_data_in, fwd_mem_data_in;
    logic [CTRL_W-1:0] id_ctrl_in;
    logic [1:0]        fwd_rs1_in, fwd_rs2_in;
    logic              ex_valid_out, ex_reg_wr_out, ex_mem_rd_out, stall_out;
    logic [4:0]        ex_rs1_out, ex_rs2_out, ex_rd_out;
    logic [XLEN-1:0]   ex_imm_out, ex_op_a_out, ex_op_b_out;
    logic [CTRL_W-1:0] ex_ctrl_out;
    logic [CNT_W-1:0]  bubble_cnt_out;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid_in(id_valid_in), .id_rs1_in(id_rs1_in),
        .id_rs2_in(id_rs2_in), .id_rd_in(id_rd_in), .id_reg_wr_in(id_reg_wr_in),
        .id_mem_rd_in(id_mem_rd_in), .id_rs1_data_in(id_rs1_data_in),
        .id_rs2_data_in(id_rs2_data_in), .id_imm_in(id_imm_in), .id_ctrl_in(id_ctrl_in),
        .stall_in(stall_in), .flush_in(flush_in), .fwd_rs1_in(fwd_rs1_in),
        .fwd_rs2_in(fwd_rs2_in), .fwd_ex_data_in(fwd_ex_data_in),
        .fwd_mem_data_in(fwd_mem_data_in), .ex_valid_out(ex_valid_out),
        .ex_rs1_out(ex_rs1_out), .ex_rs2_out(ex_rs2_out), .ex_rd_out(ex_rd_out),
        .ex_reg_wr_out(ex_reg_wr_out), .ex_mem_rd_out(ex_mem_rd_out),
        .ex_imm_out(ex_imm_out), .ex_ctrl_out(ex_ctrl_out), .ex_op_a_out(ex_op_a_out),
        .ex_op_b_out(ex_op_b_out), .stall_out(stall_out), .bubble_cnt_out(bubble_cnt_out)
    );

    // Reference: contents of the EX slot as an instruction record.
    typedef struct {
        logic              valid, reg_wr, mem_rd;
        logic [4:0]        rs1, rs2, rd;
        logic [XLEN-1:0]   d1, d2, imm;
        logic [CTRL_W-1:0] ctrl;
        int                cnt;
    } slot_t;
    typedef struct {
        slot_t           s;
        logic            stall;
        logic [XLEN-1:0] op_a, op_b;
    } exp_t;

    slot_t m;
    exp_t  q[$];
    int    vectors = 0;
    int    miscompares = 0;

    function automatic slot_t empty_slot(input int cnt);
        slot_t b;
        b = '{valid: 1'b0, reg_wr: 1'b0, mem_rd: 1'b0, rs1: '0, rs2: '0, rd: '0,
              d1: '0, d2: '0, imm: '0, ctrl: '0, cnt: cnt};
        return b;
    endfunction

    function automatic logic load_use();
        return id_valid_in && m.valid && m.mem_rd && (m.rd != 0) &&
               (id_rs1_in == m.rd || id_rs2_in == m.rd);
    endfunction

    function automatic logic [XLEN-1:0] pick(input logic [1:0] sel, input logic [XLEN-1:0] own);
        if (sel == 2'b10 || sel == 2'b11) return fwd_ex_data_in;
        if (sel == 2'b01) return fwd_mem_data_in;
        return own;
    endfunction

    task automatic model_edge();
        logic h;
        h = load_use();
        if (rst) m = empty_slot(0);
        else if (flush_in) m = empty_slot(m.cnt);
        else if (stall_in) m = m;
        else if (h) m = empty_slot((m.cnt < CNT_MAX) ? m.cnt + 1 : CNT_MAX);
        else begin
            m.valid  = id_valid_in;
            m.reg_wr = id_valid_in & id_reg_wr_in;
            m.mem_rd = id_valid_in & id_mem_rd_in;
            m.rs1 = id_rs1_in;  m.rs2 = id_rs2_in;  m.rd = id_rd_in;
            m.d1 = id_rs1_data_in;  m.d2 = id_rs2_data_in;
            m.imm = id_imm_in;  m.ctrl = id_ctrl_in;
        end
    endtask

    task automatic issue();
        exp_t e;
        e.s     = m;
        e.stall = load_use() && !flush_in;
        e.op_a  = pick(fwd_rs1_in, m.d1);
        e.op_b  = pick(fwd_rs2_in, m.d2);
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic cyc();
        issue();
        tick();
    endtask

    task automatic idle();
        rst = 0; id_valid_in = 0; id_rs1_in = 0; id_rs2_in = 0; id_rd_in = 0;
        id_reg_wr_in = 0; id_mem_rd_in = 0; id_rs1_data_in = 0; id_rs2_data_in = 0;
        id_imm_in = 0; id_ctrl_in = 0; stall_in = 0; flush_in = 0;
        fwd_rs1_in = 0; fwd_rs2_in = 0; fwd_ex_data_in = 0; fwd_mem_data_in = 0;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic wr, input logic ld,
                         input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2);
        id_valid_in = 1; id_rs1_in = rs1; id_rs2_in = rs2; id_rd_in = rd;
        id_reg_wr_in = wr; id_mem_rd_in = ld; id_rs1_data_in = d1; id_rs2_data_in = d2;
        id_imm_in = $urandom; id_ctrl_in = CTRL_W'($urandom);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: every cycle the EX slot is presented; compare against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                chk("valid",  64'(ex_valid_out),   64'(e.s.valid));
                chk("reg_wr", 64'(ex_reg_wr_out),  64'(e.s.reg_wr));
                chk("mem_rd", 64'(ex_mem_rd_out),  64'(e.s.mem_rd));
                chk("rs1",    64'(ex_rs1_out),     64'(e.s.rs1));
                chk("rs2",    64'(ex_rs2_out),     64'(e.s.rs2));
                chk("rd",     64'(ex_rd_out),      64'(e.s.rd));
                chk("imm",    64'(ex_imm_out),     64'(e.s.imm));
                chk("ctrl",   64'(ex_ctrl_out),    64'(e.s.ctrl));
                chk("op_a",   64'(ex_op_a_out),    64'(e.op_a));
                chk("op_b",   64'(ex_op_b_out),    64'(e.op_b));
                chk("stall",  64'(stall_out),      64'(e.stall));
                chk("bubble_cnt", 64'(bubble_cnt_out), 64'(e.s.cnt));
            end
        end
    end

    initial begin
        idle();
        m = empty_slot(0);
        rst = 1;
        tick(); tick();
        idle();
        cyc();                                           // reset state

        instr(1, 2, 3, 1, 0, 5, 7);  cyc();              // add x3, x1, x2
        idle();  cyc();

        instr(0, 0, 4, 1, 1, 0, 0);  cyc();              // load into x4
        instr(4, 9, 6, 1, 0, 32'h1234, 32'h55);  cyc();  // load-use -> stall_out
        cyc();                                           // bubble in EX, same instr loads
        idle(); fwd_rs1_in = 2'b01; fwd_mem_data_in = 32'hDEAD;  cyc();

        instr(0, 0, 0, 1, 1, 0, 0);  cyc();              // load to x0
        instr(0, 0, 7, 1, 0, 3, 4);  cyc();              // no hazard
        idle(); fwd_rs2_in = 2'b11; fwd_ex_data_in = 32'h11; fwd_mem_data_in = 32'h22;  cyc();

        idle(); instr(0, 0, 8, 1, 1, 9, 9);  cyc();      // load x8
        instr(5, 8, 1, 1, 0, 1, 2); flush_in = 1; stall_in = 1;  cyc();
        idle();  cyc();

        instr(3, 6, 10, 1, 0, 32'hAAAA, 32'hBBBB);  cyc();
        for (int i = 0; i < 3; i++) begin
            instr(5'($urandom), 5'($urandom), 5'($urandom), 1, 1, $urandom, $urandom);
            stall_in = 1;
            cyc();
        end
        idle();  cyc();

        for (int i = 0; i < (1 << CNT_W) + 1; i++) begin
            instr(0, 0, 5, 1, 1, 0, 0);  cyc();
            instr(5, 1, 2, 1, 0, 6, 7);  cyc();
        end
        idle();  cyc();

        instr(0, 0, 5, 1, 1, 0, 0);  cyc();
        instr(1, 5, 2, 1, 0, 6, 7); stall_in = 1;  cyc(); // hazard with downstream hold
        rst = 1;  cyc();
        idle();  cyc();

        for (int i = 0; i < 400; i++) begin
            instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), $urandom, $urandom);
            id_valid_in = ($urandom_range(0, 7) != 0);
            stall_in = ($urandom_range(0, 5) == 0);
            flush_in = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 49) == 0);
            fwd_rs1_in = 2'($urandom); fwd_rs2_in = 2'($urandom);
            fwd_ex_data_in = $urandom; fwd_mem_data_in = $urandom;
            cyc();
        end
        idle();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
